// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    localparam int PC_W    = 30;
    localparam int INSTR_W = 32;
    localparam int IMM_W   = 16;
    localparam int JT_W    = 26;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD,
        ST_DRAIN,
        ST_ERR
    } fetch_state_t;

    function automatic logic [INSTR_W-1:0] byte_addr(input logic [PC_W-1:0] word_pc);
        return {word_pc, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC arithmetic: sequential increment plus branch/jump redirect target select.
module fetch_next_pc
    import fetch_sequencer_pkg::*;
(
    input  logic [PC_W-1:0]  pc,
    input  logic             branch,
    input  logic             zero,
    input  logic             jump,
    input  logic [PC_W-1:0]  res_pc,
    input  logic [IMM_W-1:0] br_imm,
    input  logic [JT_W-1:0]  jmp_target,
    output logic [PC_W-1:0]  pc_inc,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc
);

    logic [PC_W-1:0] res_inc;
    logic [PC_W-1:0] br_pc;
    logic [PC_W-1:0] jmp_pc;

    // NOTE: every output is assigned before any branch, so no latch can be inferred.
    always_comb begin
        pc_inc      = pc + PC_W'(1);
        res_inc     = res_pc + PC_W'(1);
        br_pc       = res_inc + {{(PC_W-IMM_W){br_imm[IMM_W-1]}}, br_imm};
        jmp_pc      = {res_inc[PC_W-1:JT_W], jmp_target};
        redirect    = jump | (branch & zero);
        redirect_pc = jump ? jmp_pc : br_pc;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, decode handshake,
// redirect/squash of wrong-path fetches and a sticky memory-timeout watchdog.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              WAIT_LIMIT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_accept,
    input  logic               branch,
    input  logic               zero,
    input  logic               jump,
    input  logic [PC_W-1:0]    res_pc,
    input  logic [IMM_W-1:0]   br_imm,
    input  logic [JT_W-1:0]    jmp_target,
    output logic               fetch_err
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [31:0]     drain_addr;
    logic [CNT_W-1:0] wait_cnt;

    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] pc_inc;
    logic            timeout;

    fetch_next_pc u_next_pc (
        .pc          (pc),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .res_pc      (res_pc),
        .br_imm      (br_imm),
        .jmp_target  (jmp_target),
        .pc_inc      (pc_inc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    // The in-flight request keeps its original address while a redirect drains it.
    assign imem_addr = (state == ST_DRAIN) ? drain_addr : byte_addr(pc);
    assign timeout   = imem_req && !imem_ready && (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            drain_addr  <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (imem_req) begin
                wait_cnt <= imem_ready ? '0 : wait_cnt + CNT_W'(1);
            end

            unique case (state)
                ST_IDLE: begin
                    state    <= ST_REQ;
                    imem_req <= 1'b1;
                    if (redirect) pc <= redirect_pc;
                end
                ST_REQ: begin
                    if (timeout) begin
                        state     <= ST_ERR;
                        fetch_err <= 1'b1;
                        imem_req  <= 1'b0;
                    end else if (redirect) begin
                        pc <= redirect_pc;
                        if (!imem_ready) begin
                            state      <= ST_DRAIN;
                            drain_addr <= byte_addr(pc);
                        end
                    end else if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc_inc;
                        imem_req    <= 1'b0;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (redirect || instr_accept) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= ST_REQ;
                        if (redirect) pc <= redirect_pc;
                    end
                end
                ST_DRAIN: begin
                    if (timeout) begin
                        state     <= ST_ERR;
                        fetch_err <= 1'b1;
                        imem_req  <= 1'b0;
                    end else begin
                        if (redirect)   pc    <= redirect_pc;
                        if (imem_ready) state <= ST_REQ;
                    end
                end
                ST_ERR: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
